systolic_feeder: RTL

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder_if.sv | 20 ++
 rtl/systolic_feeder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder_if.sv
// Weight and activation stream bundle for the systolic feeder.
// Both streams use a plain valid/ready handshake.
interface systolic_feeder_if;
    logic [15:0] w_in;
    logic        w_valid_in;
    logic        w_ready_out;
    logic [31:0] a_in;
    logic        a_valid_in;
    logic        a_ready_out;

    modport master (
        output w_in, w_valid_in, a_in, a_valid_in,
        input  w_ready_out, a_ready_out
    );

    modport slave (
        input  w_in, w_valid_in, a_in, a_valid_in,
        output w_ready_out, a_ready_out
    );
endinterface

// File: rtl/systolic_feeder.sv
// Loads a 2x2 weight tile and M activation rows, then feeds them
// into the top and left edges of a 2x2 systolic array with skew.
module systolic_feeder #(
    parameter int ROWS_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cfg_m_in,
    input  logic        cfg_start_in,
    systolic_feeder_if.slave strm,
    output logic [15:0] sys_data_in_1x,
    output logic [15:0] sys_data_in_2x,
    output logic        sys_start,
    output logic [15:0] sys_weight_in_x1,
    output logic [15:0] sys_weight_in_x2,
    output logic        sys_accept_w_1,
    output logic        sys_accept_w_2,
    output logic        sys_switch_in,
    output logic [15:0] ub_rd_col_size_out,
    output logic        ub_rd_col_size_valid_out,
    output logic        busy_out,
    output logic        done_out,
    output logic        err_out
);
    localparam int CW = $clog2(ROWS_MAX + 3);
    localparam int AW = (ROWS_MAX > 1) ? $clog2(ROWS_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE, LOAD_W, LOAD_A, FEED, DONE
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, m_q;
    logic [15:0] w_q [4];
    logic [31:0] a_buf [ROWS_MAX];
    logic cfg_ok, w_fire, a_fire, err_d;
    logic [AW-1:0] ia1, ia2;

    logic        acc1_d, acc2_d, start_d;
    logic [15:0] wx1_d, wx2_d, d1_d, d2_d;

    assign strm.w_ready_out = (state_q == LOAD_W);
    assign strm.a_ready_out = (state_q == LOAD_A);
    assign w_fire = strm.w_valid_in && strm.w_ready_out;
    assign a_fire = strm.a_valid_in && strm.a_ready_out;

    assign busy_out = (state_q != IDLE);
    assign done_out = (state_q == DONE);
    assign ub_rd_col_size_valid_out = (state_q == FEED);
    assign ub_rd_col_size_out =
        (state_q == FEED) ? 16'd2 : 16'd0;

    assign cfg_ok = (cfg_m_in != 16'd0) &&
                    (cfg_m_in <= 16'(ROWS_MAX));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cfg_start_in) begin
                    if (cfg_ok) begin
                        state_d = LOAD_W;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD_W: begin
                if (w_fire) begin
                    if (cnt_q == CW'(3)) begin
                        state_d = LOAD_A;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            LOAD_A: begin
                if (a_fire) begin
                    if (cnt_q == m_q - CW'(1)) begin
                        state_d = FEED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            FEED: begin
                if (cnt_q == m_q + CW'(1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are precomputed for the cycle the FSM enters next,
    // so every sys_* signal leaves a flop.
    assign ia1 = AW'(cnt_d - CW'(1));
    assign ia2 = AW'(cnt_d - CW'(2));

    always_comb begin
        acc1_d  = 1'b0;
        acc2_d  = 1'b0;
        start_d = 1'b0;
        wx1_d   = '0;
        wx2_d   = '0;
        d1_d    = '0;
        d2_d    = '0;
        if (state_d == FEED) begin
            acc1_d = (cnt_d <= CW'(1));
            acc2_d = (cnt_d == CW'(1)) || (cnt_d == CW'(2));
            if (cnt_d == CW'(0)) wx1_d = w_q[2];
            if (cnt_d == CW'(1)) wx1_d = w_q[0];
            if (cnt_d == CW'(1)) wx2_d = w_q[3];
            if (cnt_d == CW'(2)) wx2_d = w_q[1];
            if (cnt_d >= CW'(1) && cnt_d <= m_q) begin
                start_d = 1'b1;
                d1_d    = a_buf[ia1][15:0];
            end
            if (cnt_d >= CW'(2) && cnt_d <= m_q + CW'(1))
                d2_d = a_buf[ia2][31:16];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            m_q              <= '0;
            err_out          <= 1'b0;
            sys_accept_w_1   <= 1'b0;
            sys_accept_w_2   <= 1'b0;
            sys_switch_in    <= 1'b0;
            sys_start        <= 1'b0;
            sys_weight_in_x1 <= '0;
            sys_weight_in_x2 <= '0;
            sys_data_in_1x   <= '0;
            sys_data_in_2x   <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            err_out          <= err_d;
            if (state_q == IDLE && cfg_start_in && cfg_ok)
                m_q <= CW'(cfg_m_in);
            sys_accept_w_1   <= acc1_d;
            sys_accept_w_2   <= acc2_d;
            sys_switch_in    <= acc2_d;
            sys_start        <= start_d;
            sys_weight_in_x1 <= wx1_d;
            sys_weight_in_x2 <= wx2_d;
            sys_data_in_1x   <= d1_d;
            sys_data_in_2x   <= d2_d;
        end
    end

    // Storage only; contents are irrelevant until reloaded.
    always_ff @(posedge clk) begin
        if (w_fire) w_q[cnt_q[1:0]] <= strm.w_in;
        if (a_fire) a_buf[cnt_q[AW-1:0]] <= strm.a_in;
    end
endmodule
